// File: rtl/alu_commit_arb.sv
// alu_commit_arb: round-robin merge of ALU commit streams.
// Multi-beat packets stay contiguous; 2-entry skid buffer on output.
module alu_commit_arb #(
  parameter int NUM_INPUTS = 2,
  parameter int NUM_LANES  = 4,
  parameter int XLEN       = 32,
  parameter int NW_WIDTH   = 2,
  parameter int NR_BITS    = 6,
  parameter int PID_WIDTH  = 1,
  parameter int UUID_WIDTH = 44,
  localparam int DATAW = UUID_WIDTH + NW_WIDTH + NUM_LANES + NR_BITS
                       + 1 + PID_WIDTH + 1 + 1
                       + NUM_LANES * XLEN + XLEN,
  localparam int SW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  output logic [NUM_INPUTS-1:0]       in_ready,
  input  logic [NUM_INPUTS*DATAW-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATAW-1:0]            out_data,
  output logic [SW-1:0]               out_src
);

  localparam int EOP_BIT = XLEN * (NUM_LANES + 1);

  logic [SW-1:0]         rr_q, rr_d;
  logic                  lock_q, lock_d;
  logic [SW-1:0]         lsrc_q, lsrc_d;
  logic                  v0_q, v0_d, v1_q, v1_d;
  logic [DATAW-1:0]      d0_q, d0_d, d1_q, d1_d;
  logic [SW-1:0]         s0_q, s0_d, s1_q, s1_d;

  logic [NUM_INPUTS-1:0] rdy;
  logic [NUM_INPUTS-1:0] lk;
  logic [NUM_INPUTS-1:0] hit;
  logic                  can_acc;
  logic                  acc;
  logic [SW-1:0]         g;
  logic [DATAW-1:0]      beat;
  logic                  eop;
  logic                  pop;

  // Round-robin candidates: a source is eligible when no earlier
  // source (from rr onward) is valid, so it never sees its own valid.
  always_comb begin
    int  j;
    logic blk;
    rdy = '0;
    blk = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
      if (!blk) rdy[j] = 1'b1;
      if (in_valid[j]) blk = 1'b1;
    end
  end

  // Lock overrides round-robin; full buffer or reset blocks everyone.
  always_comb begin
    lk         = '0;
    lk[lsrc_q] = 1'b1;
    can_acc    = ~v1_q & ~reset;
    in_ready   = (lock_q ? lk : rdy) & {NUM_INPUTS{can_acc}};
    hit        = in_valid & in_ready;
    acc        = |hit;
  end

  // Encode the accepted source and select its beat.
  always_comb begin
    g = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (hit[i]) g = SW'(i);
    end
    beat = in_data[int'(g)*DATAW +: DATAW];
    eop  = beat[EOP_BIT];
  end

  // Packet lock and round-robin pointer next state.
  always_comb begin
    lock_d = lock_q;
    lsrc_d = lsrc_q;
    rr_d   = rr_q;
    if (acc) begin
      if (eop) begin
        lock_d = 1'b0;
        rr_d   = (g == SW'(NUM_INPUTS - 1)) ? '0 : SW'(g + 1'b1);
      end else begin
        lock_d = 1'b1;
        lsrc_d = g;
      end
    end
  end

  // Skid FIFO: pop shifts entry1 down, push fills the first free slot.
  always_comb begin
    pop  = v0_q & out_ready;
    v0_d = v0_q;
    v1_d = v1_q;
    d0_d = d0_q;
    d1_d = d1_q;
    s0_d = s0_q;
    s1_d = s1_q;
    if (pop) begin
      v0_d = v1_q;
      d0_d = d1_q;
      s0_d = s1_q;
      v1_d = 1'b0;
    end
    if (acc) begin
      if (!v0_d) begin
        v0_d = 1'b1;
        d0_d = beat;
        s0_d = g;
      end else begin
        v1_d = 1'b1;
        d1_d = beat;
        s1_d = g;
      end
    end
  end

  // State registers; reset drops lock and any buffered beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q   <= '0;
      lock_q <= 1'b0;
      lsrc_q <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      d0_q   <= '0;
      d1_q   <= '0;
      s0_q   <= '0;
      s1_q   <= '0;
    end else begin
      rr_q   <= rr_d;
      lock_q <= lock_d;
      lsrc_q <= lsrc_d;
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      d0_q   <= d0_d;
      d1_q   <= d1_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
    end
  end

  assign out_valid = v0_q;
  assign out_data  = d0_q;
  assign out_src   = s0_q;

endmodule

// File: tb/tb_alu_commit_arb.sv
// tb_alu_commit_arb: directed table of cycles for the commit arbiter,
// plus hand sequences for reset entry/exit corner cases.
module tb_alu_commit_arb;

  localparam int DW = 220;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    in_valid;
  logic [1:0]    in_ready;
  logic [2*DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [0:0]    out_src;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  v;
    logic        e0;
    logic        e1;
    logic        ordy;
    logic        chk;
    logic [1:0]  rdy;
    logic        ov;
    logic [43:0] u;
    logic        s;
  } vec_t;

  vec_t tbl [NR];

  alu_commit_arb dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [43:0] u,
                                       input logic eop);
    return {u, u[1:0], u[3:0], u[5:0], 1'b1, u[0], 1'b1, eop,
            u[31:0] ^ 32'h3, u[31:0] ^ 32'h2,
            u[31:0] ^ 32'h1, u[31:0],
            u[31:0] ^ 32'hdead_beef};
  endfunction

  function automatic vec_t r(input logic [1:0] v,
                             input logic e0, input logic e1,
                             input logic ordy, input logic chk,
                             input logic [1:0] rdy, input logic ov,
                             input logic [43:0] u, input logic s);
    vec_t t;
    t.v = v; t.e0 = e0; t.e1 = e1; t.ordy = ordy; t.chk = chk;
    t.rdy = rdy; t.ov = ov; t.u = u; t.s = s;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [43:0] u,
                         input logic s);
    logic [DW-1:0] ref_b;
    ref_b = mk(u, 1'b0);
    chk({nm, " uuid"}, 64'(out_data[DW-1 -: 44]), 64'(u));
    chk({nm, " src"}, 64'(out_src), 64'(s));
    chk({nm, " payload"}, 64'(out_data[159:0] == ref_b[159:0]), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
    // src0 uuid = 0x10+cycle, src1 uuid = 0x100+cycle
    tbl[0]  = r(2'b11,1,1,1,1,2'b01,0,44'h0,0);
    tbl[1]  = r(2'b11,1,1,1,1,2'b10,1,44'h10,0);
    tbl[2]  = r(2'b11,1,1,1,1,2'b01,1,44'h101,1);
    tbl[3]  = r(2'b11,1,1,1,1,2'b10,1,44'h12,0);
    tbl[4]  = r(2'b11,1,1,1,1,2'b01,1,44'h103,1);
    tbl[5]  = r(2'b11,1,1,1,1,2'b10,1,44'h14,0);
    tbl[6]  = r(2'b11,1,1,1,1,2'b01,1,44'h105,1);
    tbl[7]  = r(2'b11,1,1,1,1,2'b10,1,44'h16,0);
    tbl[8]  = r(2'b11,1,1,1,1,2'b01,1,44'h107,1);
    tbl[9]  = r(2'b11,1,0,1,1,2'b10,1,44'h18,0);
    tbl[10] = r(2'b11,1,0,1,1,2'b10,1,44'h109,1);
    tbl[11] = r(2'b11,1,0,1,1,2'b10,1,44'h10a,1);
    tbl[12] = r(2'b11,1,1,1,1,2'b10,1,44'h10b,1);
    tbl[13] = r(2'b11,1,1,1,1,2'b01,1,44'h10c,1);
    tbl[14] = r(2'b11,1,1,1,1,2'b10,1,44'h1d,0);
    tbl[15] = r(2'b00,1,1,1,0,2'b00,1,44'h10e,1);
    tbl[16] = r(2'b11,1,1,0,1,2'b01,0,44'h0,0);
    tbl[17] = r(2'b11,1,1,0,1,2'b10,1,44'h20,0);
    tbl[18] = r(2'b11,1,1,0,1,2'b00,1,44'h20,0);
    tbl[19] = r(2'b11,1,1,0,1,2'b00,1,44'h20,0);
    tbl[20] = r(2'b11,1,1,0,1,2'b00,1,44'h20,0);
    tbl[21] = r(2'b11,1,1,1,1,2'b00,1,44'h20,0);
    tbl[22] = r(2'b11,1,1,1,1,2'b01,1,44'h111,1);
    tbl[23] = r(2'b11,1,1,1,1,2'b10,1,44'h26,0);
    tbl[24] = r(2'b11,0,1,1,1,2'b01,1,44'h117,1);
    tbl[25] = r(2'b11,0,1,1,1,2'b01,1,44'h28,0);
    tbl[26] = r(2'b10,0,1,1,1,2'b01,1,44'h29,0);
    tbl[27] = r(2'b10,0,1,1,1,2'b01,0,44'h0,0);
    tbl[28] = r(2'b10,0,1,1,1,2'b01,0,44'h0,0);
    tbl[29] = r(2'b11,1,1,1,1,2'b01,0,44'h0,0);
    tbl[30] = r(2'b11,1,0,0,1,2'b10,1,44'h2d,0);
    tbl[31] = r(2'b11,1,0,0,1,2'b00,1,44'h2d,0);

    reset     = 1'b1;
    in_valid  = 2'b11;
    out_ready = 1'b1;
    b0 = mk(44'h5, 1'b1);
    b1 = mk(44'h7, 1'b1);
    in_data = {b1, b0};
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_src", 64'(out_src), 64'd0);
    chk("rst out_data", 64'(out_data[63:0]), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < NR; i++) begin
      in_valid  = tbl[i].v;
      out_ready = tbl[i].ordy;
      b0 = mk(44'h10 + 44'(i), tbl[i].e0);
      b1 = mk(44'h100 + 44'(i), tbl[i].e1);
      in_data = {b1, b0};
      @(negedge clk);
      if (tbl[i].chk)
        chk($sformatf("row%0d in_ready", i), 64'(in_ready),
            64'(tbl[i].rdy));
      chk($sformatf("row%0d out_valid", i), 64'(out_valid),
          64'(tbl[i].ov));
      if (tbl[i].ov)
        chk_out($sformatf("row%0d", i), tbl[i].u, tbl[i].s);
      @(posedge clk);
      #1;
    end

    // lock held on src1 with two beats buffered: reset mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid  = 2'b11;
    out_ready = 1'b1;
    b0 = mk(44'h5, 1'b1);
    b1 = mk(44'h7, 1'b1);
    in_data = {b1, b0};
    @(negedge clk);
    chk("post rst in_ready", 64'(in_ready), 64'd1);
    chk("post rst out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post rst beat valid", 64'(out_valid), 64'd1);
    chk_out("post rst beat", 44'h5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_commit_arb.md
Name: alu_commit_arb

Overview:
- Merges the commit streams of NUM_INPUTS integer-ALU blocks into one commit stream for the writeback/commit stage.
- Arbitration is round-robin. A multi-beat packet (sop...eop, produced when NUM_LANES < NUM_THREADS) is never interleaved with another source's beats.
- A 2-entry output skid buffer gives full throughput and registered outputs.

Parameters:
- NUM_INPUTS, 2, number of upstream ALU commit sources (>=1).
- NUM_LANES, 4, lanes per beat.
- XLEN, 32, data width per lane.
- NW_WIDTH, 2, warp-id width.
- NR_BITS, 6, destination-register index width.
- PID_WIDTH, 1, packet-part-id width.
- UUID_WIDTH, 44, instruction uuid width.
- DATAW, derived = UUID_WIDTH+NW_WIDTH+NUM_LANES+NR_BITS+1+PID_WIDTH+1+1+NUM_LANES*XLEN+XLEN, beat width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_INPUTS  per-source beat valid.
- in_ready  out  NUM_INPUTS  per-source beat accepted.
- in_data  in  NUM_INPUTS*DATAW  per-source beat. Source i occupies bits [i*DATAW +: DATAW].
  - Field order MSB to LSB: uuid, wid, tmask, rd, wb, pid, sop, eop, data[NUM_LANES][XLEN], PC.
- out_valid  out  1  merged beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATAW  merged beat, same field order.
- out_src  out  max(1,clog2(NUM_INPUTS))  index of the source that produced out_data.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - out_valid=0, out_src=0, out_data=0.
  - Both skid entries empty, rr pointer=0, lock=0, locked_src=0.
- Grant, combinational each cycle:
  - If lock=1, grant = locked_src only.
  - Otherwise, grant = the first valid source at or after the rr pointer, modulo NUM_INPUTS.
- Acceptance:
  - in_ready[i] = (grant==i) && buffer_can_accept.
  - buffer_can_accept = at least one skid entry free at the start of the cycle.
  - Accept = in_valid[g] && in_ready[g].
  - in_ready must not depend on in_valid of the same source.
- Lock:
  - Set lock=1 and locked_src=g on acceptance of a beat with eop=0.
  - Clear lock on acceptance of a beat with eop=1 from locked_src.
  - A single beat with sop=eop=1 never sets the lock.
- rr pointer:
  - Updates only on acceptance of an eop=1 beat, to (g+1) mod NUM_INPUTS.
  - Lock-held beats do not move it.
- Skid buffer:
  - FIFO of depth 2. Accepted beat plus its source index is written at the clock edge.
  - out_valid = entry0 occupied. out_data and out_src are driven from registered entry0.
  - Latency is 1 cycle from input acceptance to out_valid.
  - A simultaneous push and pop keeps occupancy unchanged and supports 1 beat/cycle.
  - Full (2 entries): all in_ready = 0. out_ready=0 holds out_data stable.
- Ordering: beats from one source leave in acceptance order. Per-packet beats are contiguous on the output.
- Sources idle while locked: if locked_src drops in_valid mid-packet, no other source is granted. The arbiter waits, since upstream guarantees eventual eop.
- NUM_INPUTS=1: arbiter degenerates, out_src=0, skid behaviour unchanged.
- Reset mid-packet: lock and all buffered beats are discarded. Upstream is reset concurrently.
- Data pass-through: no field is modified. tmask=0 beats are forwarded unchanged.
- No combinational path exists from out_ready to out_valid/out_data. out_ready is allowed to reach in_ready through buffer occupancy at the same edge only.

Test Plan:
- Reset with all in_valid=1 and out_ready=1.
  - During reset: out_valid=0, in_ready=0.
  - First cycle after deassert: in_ready=2'b01.
  - Source 0 beat (uuid=5) appears on out_data one cycle later with out_src=0.
- Both sources stream single-beat packets (sop=eop=1), out_ready=1 for 8 cycles.
  - Output alternates src 0,1,0,1... at 1 beat/cycle with no bubbles.
- Source 1 sends a 4-beat packet (pid 0..3, eop on beat 3) while source 0 is continuously valid.
  - All 4 source-1 beats are contiguous on the output.
  - Source 0 is granted the cycle after the eop acceptance.
- out_ready held 0 for 5 cycles with both sources valid.
  - Exactly 2 beats are accepted, then in_ready=0.
  - out_data stays constant throughout.
  - On release, beats drain in order with no loss or duplication.
- Locked source 0 deasserts in_valid for 3 cycles after pid=1 while source 1 is valid.
  - in_ready[1] stays 0 until source 0's eop beat is accepted.
- Assert reset while lock=1 with 2 buffered beats.
  - out_valid=0 immediately (asynchronous), lock cleared.
  - After deassert, grant resumes at source 0.
